// File: rtl/axi4_lite_read_arbiter_pkg.sv
// Shared AXI4-Lite definitions: response codes and the read-arbiter state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } arb_state_e;

endpackage

// File: rtl/axi4_lite_read_arbiter_if.sv
// AXI4-Lite read bus bundle: NUM_M master-side channels plus the single slave-side channel.
// Modport master is the arbiter's view; modport slave is the surrounding system's view.
interface axi4_lite_read_arbiter_if #(
    parameter int unsigned NUM_M  = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);

    logic [NUM_M-1:0]        M_AR_VALID;
    logic [NUM_M*ADDR_W-1:0] M_AR_ADDR;
    logic [NUM_M-1:0]        M_AR_READY;
    logic [NUM_M-1:0]        M_R_VALID;
    logic [NUM_M*DATA_W-1:0] M_R_DATA;
    logic [NUM_M*2-1:0]      M_R_RESP;
    logic [NUM_M-1:0]        M_R_READY;

    logic                    S_AR_VALID;
    logic [ADDR_W-1:0]       S_AR_ADDR;
    logic                    S_AR_READY;
    logic                    S_R_VALID;
    logic [DATA_W-1:0]       S_R_DATA;
    logic [1:0]              S_R_RESP;
    logic                    S_R_READY;

    modport master (
        input  M_AR_VALID, M_AR_ADDR, M_R_READY,
        input  S_AR_READY, S_R_VALID, S_R_DATA, S_R_RESP,
        output M_AR_READY, M_R_VALID, M_R_DATA, M_R_RESP,
        output S_AR_VALID, S_AR_ADDR, S_R_READY
    );

    modport slave (
        output M_AR_VALID, M_AR_ADDR, M_R_READY,
        output S_AR_READY, S_R_VALID, S_R_DATA, S_R_RESP,
        input  M_AR_READY, M_R_VALID, M_R_DATA, M_R_RESP,
        input  S_AR_VALID, S_AR_ADDR, S_R_READY
    );

endinterface

// File: rtl/axi4_lite_read_arbiter_arb_pick.sv
// Combinational request picker: first asserted request at or after base, wrapping modulo N.
module arb_pick #(
    parameter int unsigned N    = 2,
    parameter int unsigned ID_W = 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] base,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] id
);

    localparam logic [ID_W:0] N_L = (ID_W+1)'(N);

    logic [N-1:0] rot;
    logic [ID_W:0] sum;
    logic found;

    // Rotate so base lands at bit 0, then a plain lowest-bit search suffices.
    always_comb begin
        rot   = N'({req, req} >> base);
        grant = '0;
        id    = '0;
        sum   = '0;
        found = 1'b0;
        for (int unsigned j = 0; j < N; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                sum   = {1'b0, base} + (ID_W+1)'(j);
                if (sum >= N_L) begin
                    sum = sum - N_L;
                end
                id = sum[ID_W-1:0];
            end
        end
        if (found) begin
            grant = N'(1) << id;
        end
    end

endmodule

// File: rtl/axi4_lite_read_arbiter.sv
// N-master to 1-slave AXI4-Lite read arbiter, one transaction outstanding at a time.
// Define AXI_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module axi4_lite_read_arbiter
    import axi_lite_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned NUM_M  = 2,
    parameter int unsigned ID_W   = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    axi4_lite_read_arbiter_if.master bus,
    output logic [ID_W-1:0]          GRANT_ID,
    output logic                     BUSY
);

    arb_state_e state_q, state_d;
    logic [ADDR_W-1:0] addr_q, sel_addr;
    logic [ID_W-1:0]   grant_q, base, win_id;
    logic [NUM_M-1:0]  win_oh;
    logic              load, done, r_ready;

`ifdef AXI_ARB_RR_EN
    logic [ID_W-1:0] ptr_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ptr_q <= '0;
        end else if (done) begin
            ptr_q <= (grant_q == ID_W'(NUM_M-1)) ? '0 : grant_q + 1'b1;
        end
    end

    assign base = ptr_q;
`else
    assign base = '0;
`endif

    arb_pick #(.N(NUM_M), .ID_W(ID_W)) u_pick (
        .req   (bus.M_AR_VALID),
        .base  (base),
        .grant (win_oh),
        .id    (win_id)
    );

    always_comb begin
        sel_addr = '0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (win_oh[i]) begin
                sel_addr = bus.M_AR_ADDR[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
            addr_q  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                addr_q  <= sel_addr;
                grant_q <= win_id;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.M_AR_READY = '0;
        bus.M_R_VALID  = '0;
        r_ready        = 1'b0;
        load           = 1'b0;
        done           = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.M_AR_VALID) begin
                    bus.M_AR_READY = win_oh;
                    load           = 1'b1;
                    state_d        = ADDR;
                end
            end
            ADDR: begin
                if (bus.S_AR_READY) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                for (int unsigned i = 0; i < NUM_M; i++) begin
                    if (grant_q == ID_W'(i)) begin
                        bus.M_R_VALID[i] = bus.S_R_VALID;
                        r_ready          = bus.M_R_READY[i];
                    end
                end
                if (bus.S_R_VALID && r_ready) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.S_R_READY  = r_ready;
    assign bus.S_AR_VALID = (state_q == ADDR);
    assign bus.S_AR_ADDR  = addr_q;
    assign bus.M_R_DATA   = {NUM_M{bus.S_R_DATA}};
    assign bus.M_R_RESP   = {NUM_M{bus.S_R_RESP}};
    assign GRANT_ID       = grant_q;
    assign BUSY           = (state_q != IDLE);

endmodule
